// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : mmio_uart_tx
// Brief    : picorv32 native-bus UART transmitter: TX FIFO feeding an 8N1
//            serializer. Define MMIO_UART_TX_IRQ_EN for the TX-done interrupt.
// Revision : 1.0
// ============================================================================
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        uart_tx,
    output logic        irq
);
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
    localparam logic [c_CW-1:0] c_CNT_FULL = c_CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic              r_ready;
    logic [31:0]       r_rdata;
    logic [15:0]       r_div;
    logic              r_ovf;
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;
    state_t            r_state;
    state_t            w_state_next;
    logic [7:0]        r_shift;
    logic [15:0]       r_period;
    logic [15:0]       r_baud;
    logic [2:0]        r_bit;

    logic        w_hit, w_wr, w_rd;
    logic [1:0]  w_off;
    logic        w_push_req, w_push_ok, w_pop;
    logic        w_ovf_clr, w_div_wr;
    logic        w_full, w_empty, w_busy, w_ie;
    logic        w_tick, w_tx;
    logic [7:0]  w_cnt8;
    logic [31:0] w_rd_val;
    logic        w_unused_ok;

    // Fetches decode like data reads; byte lanes/bits below are never consulted.
    assign w_unused_ok = &{1'b0, mem_instr, mem_addr[1:0], mem_wdata[31:16]};

    assign w_hit      = mem_valid && !r_ready && (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign w_wr       = w_hit && (mem_wstrb != 4'b0000);
    assign w_rd       = w_hit && (mem_wstrb == 4'b0000);
    assign w_off      = mem_addr[3:2];
    assign w_push_req = w_wr && (w_off == 2'd0) && mem_wstrb[0];
    assign w_ovf_clr  = w_wr && (w_off == 2'd1) && mem_wdata[3];
    assign w_div_wr   = w_wr && (w_off == 2'd2) && (mem_wstrb[1:0] == 2'b11);

    assign w_full    = (r_count == c_CNT_FULL);
    assign w_empty   = (r_count == '0);
    assign w_busy    = (r_state != S_IDLE);
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign w_push_ok = w_push_req && (!w_full || w_pop);
    assign w_cnt8    = 8'(r_count);

    always_comb begin
        w_rd_val = 32'd0;
        case (w_off)
            2'd1:    w_rd_val = {16'd0, w_cnt8, 3'b000, w_ie, r_ovf, w_busy, w_empty, w_full};
            2'd2:    w_rd_val = {16'd0, r_div};
            default: w_rd_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready <= 1'b0;
            r_rdata <= 32'd0;
            r_div   <= DEFAULT_DIV;
            r_ovf   <= 1'b0;
        end else begin
            r_ready <= w_hit;
            r_rdata <= w_rd ? w_rd_val : 32'd0;
            if (w_div_wr) begin
                r_div <= mem_wdata[15:0];
            end
            if (w_push_req && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= mem_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_tx         = 1'b1;
        w_tick       = (r_baud == (r_period - 16'd1));
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                w_tx = 1'b0;
                if (w_tick) w_state_next = S_DATA;
            end
            S_DATA: begin
                w_tx = r_shift[0];
                if (w_tick && (r_bit == 3'd7)) w_state_next = S_STOP;
            end
            S_STOP: begin
                if (w_tick) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // The bit period is captured at pop so a DIV write only affects later frames.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift  <= 8'd0;
            r_period <= 16'd1;
            r_baud   <= 16'd0;
            r_bit    <= 3'd0;
        end else if (w_pop) begin
            r_shift  <= r_mem[r_rd_ptr];
            r_period <= (r_div == 16'd0) ? 16'd1 : r_div;
            r_baud   <= 16'd0;
            r_bit    <= 3'd0;
        end else if (r_state != S_IDLE) begin
            if (w_tick) begin
                r_baud <= 16'd0;
                if (r_state == S_DATA) begin
                    r_shift <= {1'b0, r_shift[7:1]};
                    r_bit   <= r_bit + 3'd1;
                end
            end else begin
                r_baud <= r_baud + 16'd1;
            end
        end
    end

`ifdef MMIO_UART_TX_IRQ_EN
    logic r_ie;
    logic r_irq;
    logic w_ie_wr;
    logic w_ie_next;

    assign w_ie_wr   = w_wr && (w_off == 2'd1) && mem_wstrb[0];
    assign w_ie_next = w_ie_wr ? mem_wdata[4] : r_ie;

    // Drops together with the push or IE clear that ends the idle condition.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ie  <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            r_ie  <= w_ie_next;
            r_irq <= w_ie_next && w_empty && !w_busy && !w_push_ok;
        end
    end

    assign w_ie = r_ie;
    assign irq  = r_irq;
`else
    assign w_ie = 1'b0;
    assign irq  = 1'b0;
`endif

    assign mem_ready = r_ready;
    assign mem_rdata = r_rdata;
    assign uart_tx   = w_tx;

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_uart_tx
// Brief    : Self-checking bench for mmio_uart_tx: register vector table,
//            serial-frame scoreboard and hand-written timing sequences.
// Revision : 1.0
// ============================================================================
module tb_mmio_uart_tx;
    localparam logic [31:0] c_BASE   = 32'h1000_0000;
    localparam logic [31:0] c_STATUS = c_BASE + 32'h4;
    localparam logic [31:0] c_DIV    = c_BASE + 32'h8;
`ifdef MMIO_UART_TX_IRQ_EN
    localparam logic [31:0] c_IE = 32'h10;
`else
    localparam logic [31:0] c_IE = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        uart_tx;
    logic        irq;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cur_p    = 868;
    bit         mon_en   = 1'b0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        instr;
        logic [31:0] exp;
    } vec_t;

    mmio_uart_tx #(
        .BASE_ADDR  (c_BASE),
        .FIFO_DEPTH (8),
        .DEFAULT_DIV(16'd868)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_valid(mem_valid),
        .mem_instr(mem_instr),
        .mem_ready(mem_ready),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata),
        .uart_tx  (uart_tx),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rdata);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        tick();
        check("ready_pulse", {31'd0, mem_ready}, 32'd1);
        rdata     = mem_rdata;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        tick();
        check("ready_low", {31'd0, mem_ready}, 32'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        xfer(a, d, s, dummy);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        xfer(a, 32'h0, 4'h0, d);
    endtask

    task automatic push(input logic [7:0] b);
        wr(c_BASE, {24'h0, b}, 4'b0001);
    endtask

    task automatic wait_idle(input int budget);
        logic [31:0] st;
        int          n;
        n = 0;
        do begin
            rd(c_STATUS, st);
            n++;
        end while (((st & 32'hFFFF_FFEF) != 32'h2) && (n < budget));
        check("idle_reached", st & 32'hFFFF_FFEF, 32'h2);
        check("scoreboard_drained", exp_q.size(), 32'd0);
    endtask

    // Serial monitor: decodes frames at the bench's notion of the bit period.
    initial begin : mon
        int         p;
        int         k;
        logic [7:0] b;
        logic       stop;
        bit         abort;
        forever begin
            tick();
            if (mon_en && uart_tx === 1'b0) begin
                p = cur_p; k = 0; b = 8'h00; stop = 1'b0; abort = 1'b0;
                for (int i = 0; i <= 8; i++) begin
                    while (!abort && k < (i + 1) * p + p / 2) begin
                        tick();
                        k++;
                        if (!mon_en) abort = 1'b1;
                    end
                    if (i < 8) b = {uart_tx, b[7:1]};
                    else       stop = uart_tx;
                end
                if (!abort) begin
                    check("frame_stop", {31'd0, stop}, 32'd1);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL frame_unexpected: got byte 0x%02h, expected no frame", b);
                    end else begin
                        check("frame_data", {24'd0, b}, {24'd0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t        vecs [18];
        logic [31:0] rdata;
        logic [7:0]  pat;
        int          cnt;
        int          bad;

        vecs[0]  = '{c_STATUS,         32'h0,         4'h0, 1'b0, 32'h2};
        vecs[1]  = '{c_DIV,            32'h0,         4'h0, 1'b0, 32'h364};
        vecs[2]  = '{c_BASE,           32'h0,         4'h0, 1'b1, 32'h0};
        vecs[3]  = '{c_BASE + 32'hC,   32'h0,         4'h0, 1'b0, 32'h0};
        vecs[4]  = '{c_DIV,            32'h1234,      4'h1, 1'b0, 32'h0};
        vecs[5]  = '{c_DIV,            32'h0,         4'h0, 1'b0, 32'h364};
        vecs[6]  = '{c_DIV,            32'hABCD_0007, 4'h3, 1'b0, 32'h0};
        vecs[7]  = '{c_DIV,            32'h0,         4'h0, 1'b1, 32'h7};
        vecs[8]  = '{c_BASE + 32'hC,   32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0};
        vecs[9]  = '{c_BASE + 32'hC,   32'h0,         4'h0, 1'b0, 32'h0};
        vecs[10] = '{c_STATUS,         32'h18,        4'h1, 1'b0, 32'h0};
        vecs[11] = '{c_STATUS,         32'h0,         4'h0, 1'b0, 32'h2 | c_IE};
        vecs[12] = '{c_STATUS,         32'h0,         4'h2, 1'b0, 32'h0};
        vecs[13] = '{c_STATUS,         32'h0,         4'h0, 1'b0, 32'h2 | c_IE};
        vecs[14] = '{c_STATUS,         32'h0,         4'h1, 1'b0, 32'h0};
        vecs[15] = '{c_STATUS,         32'h0,         4'h0, 1'b0, 32'h2};
        vecs[16] = '{c_BASE,           32'hAA,        4'h2, 1'b0, 32'h0};
        vecs[17] = '{c_STATUS,         32'h0,         4'h0, 1'b0, 32'h2};

        reset = 1'b1; mem_valid = 1'b0; mem_instr = 1'b0;
        mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
        repeat (3) tick();
        check("rst_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_irq", {31'd0, irq}, 32'd0);
        reset  = 1'b0;
        tick();
        mon_en = 1'b1;

        for (int i = 0; i < 18; i++) begin
            mem_instr = vecs[i].instr;
            xfer(vecs[i].addr, vecs[i].wdata, vecs[i].strb, rdata);
            if (vecs[i].strb == 4'h0) check($sformatf("vec%0d", i), rdata, vecs[i].exp);
        end

        // Valid held across the response: no back-to-back hit on the ready cycle.
        mem_valid = 1'b1; mem_addr = c_STATUS; mem_wstrb = 4'h0;
        tick();
        check("hold_ready1", {31'd0, mem_ready}, 32'd1);
        tick();
        check("hold_gap", {31'd0, mem_ready}, 32'd0);
        tick();
        check("hold_ready2", {31'd0, mem_ready}, 32'd1);
        mem_valid = 1'b0;
        tick();

        // Out-of-window accesses stay silent and push nothing.
        for (int j = 0; j < 3; j++) begin
            cnt = 0;
            mem_valid = 1'b1;
            mem_addr  = (j == 0) ? 32'h2000_0000 : (j == 1) ? c_BASE + 32'h10 : c_BASE - 32'h4;
            mem_wdata = 32'h5A; mem_wstrb = 4'hF;
            for (int c = 0; c < 20; c++) begin
                tick();
                if (mem_ready !== 1'b0) cnt++;
            end
            mem_valid = 1'b0;
            tick();
            check($sformatf("miss%0d_ready", j), cnt, 32'd0);
        end
        rd(c_STATUS, rdata);
        check("miss_status", rdata, 32'h2);

        // Exact 0x55 waveform at DIV=4 with a concurrent STATUS read.
        wr(c_DIV, 32'd4, 4'h3);
        cur_p = 4;
        exp_q.push_back(8'h55);
        push(8'h55);
        pat = 8'h55;
        fork
            begin
                bad = 0;
                for (int c = 0; c <= 40; c++) begin
                    if (uart_tx !== ((c < 4) ? 1'b0 : (c < 36) ? pat[(c / 4) - 1] : 1'b1)) bad++;
                    if (c < 40) tick();
                end
                check("frame55_wave_errs", bad, 32'd0);
            end
            begin
                repeat (8) tick();
                rd(c_STATUS, rdata);
                check("frame55_status_busy", rdata, 32'h6);
            end
        join
        wait_idle(50);

        // Nine back-to-back pushes at DIV=2: the first is popped at once, none dropped.
        wr(c_DIV, 32'd2, 4'h3);
        cur_p = 2;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(8'h30 + 8'(i));
            push(8'h30 + 8'(i));
        end
        rd(c_STATUS, rdata);
        check("burst_status", rdata, 32'h0805);
        wait_idle(300);

        // DIV=3: FIFO fills, pushes overflow, and one push coincides with the pop.
        wr(c_DIV, 32'd3, 4'h3);
        cur_p = 3;
        for (int k = 0; k <= 17; k++) begin
            if (k <= 8 || k == 16) exp_q.push_back(8'h60 + 8'(k));
            push(8'h60 + 8'(k));
        end
        rd(c_STATUS, rdata);
        check("ovf_status", rdata, 32'h080D);
        wr(c_STATUS, 32'h8, 4'h1);
        rd(c_STATUS, rdata);
        check("ovf_cleared", rdata, 32'h0805);
        wait_idle(400);

        // Reset during bit 3 of 0xA5.
        wr(c_DIV, 32'd4, 4'h3);
        cur_p = 4;
        exp_q.push_back(8'hA5);
        push(8'hA5);
        repeat (17) tick();
        check("midframe_low", {31'd0, uart_tx}, 32'd0);
        mon_en = 1'b0;
        reset  = 1'b1;
        tick();
        check("midrst_tx", {31'd0, uart_tx}, 32'd1);
        check("midrst_ready", {31'd0, mem_ready}, 32'd0);
        check("midrst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        exp_q.delete();
        cur_p = 868;
        tick();
        rd(c_STATUS, rdata);
        check("midrst_status", rdata, 32'h2);
        rd(c_DIV, rdata);
        check("midrst_div", rdata, 32'h364);
        cnt = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (uart_tx !== 1'b1) cnt++;
        end
        check("midrst_line_idle", cnt, 32'd0);
        mon_en = 1'b1;

        wr(c_DIV, 32'd1, 4'h3);
        cur_p = 1;
`ifdef MMIO_UART_TX_IRQ_EN
        wr(c_STATUS, 32'h10, 4'h1);
        check("irq_idle_level", {31'd0, irq}, 32'd1);
        exp_q.push_back(8'h3C);
        push(8'h3C);
        check("irq_clr_push", {31'd0, irq}, 32'd0);
        repeat (10) tick();
        check("irq_stop_end", {31'd0, irq}, 32'd0);
        check("irq_stop_line", {31'd0, uart_tx}, 32'd1);
        tick();
        check("irq_rise", {31'd0, irq}, 32'd1);
        exp_q.push_back(8'h3D);
        push(8'h3D);
        check("irq_clr_push2", {31'd0, irq}, 32'd0);
        wait_idle(40);
        check("irq_after_frame", {31'd0, irq}, 32'd1);
        wr(c_STATUS, 32'h0, 4'h1);
        check("irq_clr_ie", {31'd0, irq}, 32'd0);
`else
        wr(c_STATUS, 32'h10, 4'h1);
        rd(c_STATUS, rdata);
        check("noirq_status", rdata, 32'h2);
        exp_q.push_back(8'h3C);
        push(8'h3C);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (irq !== 1'b0) cnt++;
        end
        check("noirq_level", cnt, 32'd0);
        wait_idle(40);
`endif

        check("final_scoreboard", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the picorv32 native memory bus, placed beside the main RAM as the first MMIO slave.
- The CPU writes bytes into a TX FIFO. A serializer drains the FIFO onto uart_tx as 8N1 frames, LSB first.
- Decodes its own address window. Outside that window it stays silent, so the RAM or other slaves answer.

Parameters:
- BASE_ADDR, 32'h1000_0000, base of a 16-byte register window; must be 16-byte aligned.
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of two and at least 2.
- DEFAULT_DIV, 16'd868, reset value of DIV (clocks per bit).

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- mem_valid  in  1  bus request valid.
- mem_instr  in  1  instruction fetch; ignored, fetches decode like data reads.
- mem_ready  out  1  one-cycle response pulse.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte strobes; 0 means read.
- mem_rdata  out  32  read data, valid while mem_ready=1.
- uart_tx  out  1  serial line, idles high.
- irq  out  1  TX-done interrupt (see Optional Feature).

Behaviour:
- Reset values:
  - mem_ready=0, mem_rdata=0, uart_tx=1, irq=0.
  - FIFO empty, serializer IDLE, DIV=DEFAULT_DIV, OVF=0, IE=0.
- Decode: hit = mem_valid && !mem_ready && mem_addr[31:4]==BASE_ADDR[31:4]. No hit means mem_ready stays 0.
- Response: a hit in cycle N gives mem_ready=1 for exactly cycle N+1, then 0. Both read and write take 1 wait cycle.
- Register map (offset = mem_addr[3:2]):
  - 0x0 TXDATA:
    - Write with wstrb[0]=1 pushes wdata[7:0]. Other strobes ignored.
    - Read returns 0.
  - 0x4 STATUS, read:
    - bit0 FULL, bit1 EMPTY, bit2 BUSY (serializer not IDLE), bit3 OVF, bit4 IE.
    - bits[15:8] FIFO count; all other bits 0.
  - 0x4 STATUS, write:
    - wdata[3]=1 clears OVF.
    - If wstrb[0]=1, IE = wdata[4].
  - 0x8 DIV: read/write, bits[15:0]. Write requires wstrb[1:0]==2'b11, otherwise ignored. Upper bits read 0.
  - 0xC: reserved. Reads return 0, writes ignored, mem_ready still pulses.
- FIFO:
  - Push to a full FIFO drops the byte and sets sticky OVF, except when a pop happens in the same cycle. In that case the push is accepted and count is unchanged.
  - Push and pop when not full: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Count range is 0..FIFO_DEPTH.
- Serializer states: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE:
    - uart_tx=1.
    - If FIFO not empty: pop into shift register, latch bit period P = (DIV==0 ? 1 : DIV), go to START.
  - START: uart_tx=0 for P clocks.
  - DATA: 8 bits LSB first, each held P clocks. A 3-bit counter tracks the bit index.
  - STOP: uart_tx=1 for P clocks, then IDLE.
  - Back-to-back bytes: STOP->IDLE->START adds exactly 1 idle-high clock between frames.
  - A DIV write mid-frame affects only the next frame.
  - Frame length is 10*P+1 clocks from pop to the next possible pop.
- Reset mid-frame: uart_tx returns high next cycle, FIFO is flushed, no partial-frame completion.

Optional Feature:
- Macro MMIO_UART_TX_IRQ_EN.
- Defined:
  - irq is registered: irq = IE && EMPTY && !BUSY.
  - Asserts 1 cycle after the last stop bit ends. Level, not pulse.
  - Clears when a byte is pushed or IE is cleared.
- Undefined:
  - irq is constant 0.
  - IE bit is not implemented: STATUS bit4 reads 0 and writes are ignored.

Test Plan:
- Reset, then read BASE+0x4 -> mem_ready one cycle after request; rdata=32'h0000_0002 (EMPTY only); uart_tx=1 throughout.
- Write DIV=4, then TXDATA=0x55 -> uart_tx low 4 clks, then bits 1,0,1,0,1,0,1,0 at 4 clks each, then high 4 clks; STATUS bit2=1 during the frame.
- DIV=2, push 9 bytes without pause (FIFO_DEPTH=8) -> one of them is popped immediately, so none dropped and OVF=0. Push 10 more while the serializer is busy -> the overflowed pushes set OVF, count reads 8. Write STATUS wdata=0x8 -> OVF=0.
- Access 0x2000_0000 with mem_valid held high -> mem_ready stays 0 for 20 cycles. Read BASE+0xC -> ready pulse, rdata=0.
- Assert reset mid-frame (bit 3 of 0xA5) -> next cycle uart_tx=1, STATUS reads 0x2, no further frames.
- With MMIO_UART_TX_IRQ_EN: set IE and send 1 byte at DIV=1 -> irq rises exactly 1 cycle after the stop bit ends; a TXDATA write drops irq to 0. Without the macro -> irq stays 0.
